imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Streaming instruction assembler. It packs register, funct3 and opcode fields plus a 32-bit signed immediate into a 32-bit RV32I I-, S- or B-type instruction word. Range and alignment are checked before packing. It sits in the boot-loader / self-test path, generating instruction words into instruction memory. It is the inverse of the immediate extender, and uses the same ImmSrc encoding: 00 I, 01 S, 10 B.

Parameters:
CNT_W, 16, width of the saturating error counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input fields valid
in_ready  out  1  encoder can accept input
ImmSrc  in  2  format select: 00 I, 01 S, 10 B, 11 illegal
opcode  in  7  instruction[6:0]
rd  in  5  destination register (I only)
rs1  in  5  source register 1
rs2  in  5  source register 2 (S/B only)
funct3  in  3  instruction[14:12]
imm  in  32  signed immediate, byte offset for B
out_valid  out  1  instruction word valid
out_ready  in  1  consumer accepts word
instr_out  out  32  packed instruction
err_out  out  1  word was replaced by NOP due to error
err_code  out  2  00 none, 01 range, 10 misaligned, 11 bad ImmSrc
err_count  out  CNT_W  saturating count of errored words delivered
err_clr  in  1  synchronous clear of err_count

Behaviour:
- Reset (async assert, sync release): both stage valids 0, out_valid 0, instr_out 0, err_out 0, err_code 00, err_count 0. Reset mid-stream discards in-flight words; no partial output.
- Pipeline has two registered stages:
  - S1 captures the input fields.
  - S2 holds the packed word, check result and error flags; S2 drives the outputs.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 word/cycle.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - in_ready = !s1_valid || s1 advances; s1 advances when !s2_valid || out_ready. in_ready is combinational from out_ready.
  - Once out_valid is asserted, out_valid, instr_out, err_out and err_code hold stable until out_ready.
  - Order is preserved and no word is lost or duplicated under any backpressure pattern.
- Checks (combinational, between S1 and S2):
  - bad ImmSrc: ImmSrc==11.
  - misaligned: B and imm[0]==1.
  - range, I/S: imm[31:11] not all equal (valid range -2048..2047).
  - range, B: imm[31:12] not all equal (valid range -4096..4094).
  - Priority when several apply: bad ImmSrc > misaligned > range.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - Unused field inputs are ignored.
- On any error: instr_out = 32'h00000013 (addi x0,x0,0), err_out=1, err_code set.
- err_count:
  - Increments by 1 on an output handshake with err_out=1.
  - Saturates at all-ones.
  - err_clr forces 0 next cycle and wins over a simultaneous increment.

Decomposition:
- Package imm_enc_pkg:
  - ImmSrc constants IMM_I/IMM_S/IMM_B.
  - err_code enum ERR_NONE/ERR_RANGE/ERR_ALIGN/ERR_SRC.
  - NOP_INSTR constant 32'h00000013.
  - Packed struct for stage-1 fields.
- One combinational sub-module, imm_pack: fields in, {instr, err_code} out, containing the check and pack logic. The top level holds the pipeline, handshake and counter.

Test Plan:
- I addi x1,x2,-1 (opcode 0010011, rd=1, rs1=2, f3=0, imm=32'hFFFFFFFF), out_ready=1 -> out_valid 2 cycles later, instr_out=32'hFE... no: instr_out=32'hFFF10093, err_out=0.
- S sw x5,8(x2) (opcode 0100011, f3=010, rs1=2, rs2=5, imm=8) -> 32'h00512423. B beq x1,x2,-4 (opcode 1100011, f3=0, rs1=1, rs2=2, imm=-4) -> 32'hFE208EE3.
- Errors, in order: I imm=2048 -> 32'h00000013, code 01; B imm=5 -> code 10; ImmSrc=11 with imm=5000 -> code 11; err_count ends at 3.
- Backpressure: hold out_ready=0 and offer 3 back-to-back words -> 2 accepted, then in_ready=0 and outputs stable. Release out_ready -> all 3 delivered in order, no duplicates. Also run random valid/ready toggling over 1000 words, compared against a reference model.
- Counter: preload by driving 2^CNT_W+2 errored words -> holds at all-ones. Assert err_clr coincident with an errored handshake -> err_count=0.
- Assert rst_n low mid-stream with both stages full -> outputs reset immediately (async). After release, only new inputs appear, with 2-cycle latency.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg: shared constants and types for the RV32I immediate encoder.
package imm_enc_pkg;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_SRC   = 2'b11
  } err_code_e;
  typedef struct packed {
    logic [1:0]  imm_src;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } s1_fields_t;
endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: field-input stream, instruction-output stream and error counter bus.
interface imm_encoder_if #(parameter int CNT_W = 16) ();
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       ImmSrc;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr_out;
  logic             err_out;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] err_count;
  logic             err_clr;
  modport master (
    output in_valid, ImmSrc, opcode, rd, rs1, rs2, funct3, imm, out_ready, err_clr,
    input  in_ready, out_valid, instr_out, err_out, err_code, err_count
  );
  modport slave (
    input  in_valid, ImmSrc, opcode, rd, rs1, rs2, funct3, imm, out_ready, err_clr,
    output in_ready, out_valid, instr_out, err_out, err_code, err_count
  );
endinterface

// File: rtl/imm_pack.sv
// imm_pack: range/alignment checks and I/S/B field packing; errors yield a NOP.
module imm_pack
  import imm_enc_pkg::*;
(
  input  s1_fields_t  f_i,
  output logic [31:0] instr_o,
  output err_code_e   err_o
);
  logic        bad_is;
  logic        bad_b;
  logic [31:0] word_i;
  logic [31:0] word_s;
  logic [31:0] word_b;
  // In range means the upper bits are a pure sign extension.
  assign bad_is = !((&f_i.imm[31:11]) || !(|f_i.imm[31:11]));
  assign bad_b  = !((&f_i.imm[31:12]) || !(|f_i.imm[31:12]));
  assign word_i = {f_i.imm[11:0], f_i.rs1, f_i.funct3, f_i.rd, f_i.opcode};
  assign word_s = {f_i.imm[11:5], f_i.rs2, f_i.rs1, f_i.funct3, f_i.imm[4:0], f_i.opcode};
  assign word_b = {f_i.imm[12], f_i.imm[10:5], f_i.rs2, f_i.rs1, f_i.funct3,
                   f_i.imm[4:1], f_i.imm[11], f_i.opcode};
  always_comb begin
    err_o   = (f_i.imm_src == 2'b11)                ? ERR_SRC   :
              (f_i.imm_src == IMM_B && f_i.imm[0])  ? ERR_ALIGN :
              ((f_i.imm_src == IMM_B) ? bad_b : bad_is) ? ERR_RANGE : ERR_NONE;
    instr_o = (err_o != ERR_NONE)       ? NOP_INSTR :
              (f_i.imm_src == IMM_I)    ? word_i    :
              (f_i.imm_src == IMM_S)    ? word_s    : word_b;
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline around imm_pack with a saturating error counter.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  imm_encoder_if.slave  bus
);
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  s1_fields_t       s1_q, s1_d;
  logic [31:0]      s2_instr_q, s2_instr_d;
  err_code_e        s2_err_q, s2_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]      pk_instr;
  err_code_e        pk_err;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;
  logic             s2_load;
  imm_pack u_pack (
    .f_i     (s1_q),
    .instr_o (pk_instr),
    .err_o   (pk_err)
  );
  assign s1_adv        = !s2_valid_q || bus.out_ready;
  assign bus.in_ready  = !s1_valid_q || s1_adv;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = s2_valid_q && bus.out_ready;
  assign s2_load       = s1_adv && s1_valid_q;
  assign bus.out_valid = s2_valid_q;
  assign bus.instr_out = s2_instr_q;
  assign bus.err_out   = s2_err_q != ERR_NONE;
  assign bus.err_code  = s2_err_q;
  assign bus.err_count = err_count_q;
  always_comb begin
    s1_valid_d  = bus.in_ready ? bus.in_valid : s1_valid_q;
    s1_d        = in_fire ? '{imm_src: bus.ImmSrc, opcode: bus.opcode, rd: bus.rd,
                              rs1: bus.rs1, rs2: bus.rs2, funct3: bus.funct3, imm: bus.imm}
                          : s1_q;
    s2_valid_d  = s1_adv ? s1_valid_q : s2_valid_q;
    s2_instr_d  = s2_load ? pk_instr : s2_instr_q;
    s2_err_d    = s2_load ? pk_err : s2_err_q;
    // Clear beats a same-cycle increment; all-ones is sticky.
    err_count_d = bus.err_clr ? '0 :
                  (out_fire && s2_err_q != ERR_NONE && !(&err_count_q)) ? err_count_q + CNT_W'(1)
                                                                        : err_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_instr_q  <= '0;
      s2_err_q    <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_q        <= s1_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
    end
  end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vector table, corner sequences and randomized backpressure vs a reference model.
module tb_imm_encoder;
  import imm_enc_pkg::*;
  localparam int CW = 4;
  typedef struct packed {
    logic [31:0] instr;
    logic [1:0]  code;
  } exp_t;
  typedef struct packed {
    s1_fields_t  f;
    logic [31:0] instr;
    logic [1:0]  code;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  bit rand_bp = 1'b0;
  int cnt_m = 0;
  bit stall_prev = 1'b0;
  logic [31:0] prev_instr;
  logic [1:0] prev_code;
  imm_encoder_if #(.CNT_W(CW)) bus ();
  imm_encoder #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic s1_fields_t mk(input int src, input int op, input int rd, input int rs1,
                                    input int rs2, input int f3, input int imm);
    s1_fields_t f;
    f.imm_src = src[1:0];
    f.opcode  = op[6:0];
    f.rd      = rd[4:0];
    f.rs1     = rs1[4:0];
    f.rs2     = rs2[4:0];
    f.funct3  = f3[2:0];
    f.imm     = imm;
    return f;
  endfunction
  // Reference: decide legality from the signed value, then place fields arithmetically.
  function automatic exp_t model(input s1_fields_t f);
    exp_t e;
    longint v = longint'($signed(f.imm));
    longint u = longint'(f.imm);
    longint base = (longint'(f.rs1) << 15) | (longint'(f.funct3) << 12) | longint'(f.opcode);
    longint w;
    if (f.imm_src == 2'd3) e.code = 2'd3;
    else if (f.imm_src == 2'd2 && (v % 2) != 0) e.code = 2'd2;
    else if (f.imm_src == 2'd2 && (v < -4096 || v > 4095)) e.code = 2'd1;
    else if (f.imm_src != 2'd2 && (v < -2048 || v > 2047)) e.code = 2'd1;
    else e.code = 2'd0;
    if (f.imm_src == 2'd0)
      w = base | ((u % 4096) << 20) | (longint'(f.rd) << 7);
    else if (f.imm_src == 2'd1)
      w = base | (((u / 32) % 128) << 25) | (longint'(f.rs2) << 20) | ((u % 32) << 7);
    else
      w = base | (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) | (longint'(f.rs2) << 20)
               | (((u / 2) % 16) << 8) | (((u / 2048) % 2) << 7);
    e.instr = (e.code != 2'd0) ? 32'h13 : w[31:0];
    return e;
  endfunction
  task automatic drive(input s1_fields_t f);
    bus.ImmSrc = f.imm_src;
    bus.opcode = f.opcode;
    bus.rd     = f.rd;
    bus.rs1    = f.rs1;
    bus.rs2    = f.rs2;
    bus.funct3 = f.funct3;
    bus.imm    = f.imm;
  endtask
  task automatic send(input s1_fields_t f);
    bit ok = 1'b0;
    bit acc;
    drive(f);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      ok = acc;
    end
    bus.in_valid = 1'b0;
    if (ok) exp_q.push_back(model(f));
    else chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic send_lat(input s1_fields_t f, input logic [31:0] ei, input logic [1:0] ec);
    send(f);
    @(negedge clk);
    chk("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_instr", bus.instr_out, ei);
    chk("lat_code", {30'd0, bus.err_code}, {30'd0, ec});
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask
  always @(posedge clk) if (rand_bp) begin
    #1;
    bus.out_ready = ($urandom % 3) != 0;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_m = 0;
      stall_prev = 1'b0;
    end else begin
      exp_t e;
      chk("err_count", {{(32-CW){1'b0}}, bus.err_count}, cnt_m);
      if (stall_prev) begin
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_instr", bus.instr_out, prev_instr);
        chk("stall_code", {30'd0, bus.err_code}, {30'd0, prev_code});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", bus.instr_out, 32'hxxxx_xxxx);
        else begin
          e = exp_q.pop_front();
          chk("sb_instr", bus.instr_out, e.instr);
          chk("sb_code", {30'd0, bus.err_code}, {30'd0, e.code});
          chk("sb_err_out", {31'd0, bus.err_out}, {31'd0, e.code != 2'd0});
        end
      end
      if (bus.err_clr) cnt_m = 0;
      else if (bus.out_valid && bus.out_ready && bus.err_out && cnt_m != (1 << CW) - 1) cnt_m++;
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_instr = bus.instr_out;
      prev_code  = bus.err_code;
    end
  end
  initial begin
    vec_t vt[15];
    s1_fields_t fa, fb, fc;
    vt[0]  = '{mk(0, 'h13, 1, 2, 0, 0, -1),    32'hFFF10093, 2'd0};
    vt[1]  = '{mk(1, 'h23, 0, 2, 5, 2, 8),     32'h00512423, 2'd0};
    vt[2]  = '{mk(2, 'h63, 0, 1, 2, 0, -4),    32'hFE208EE3, 2'd0};
    vt[3]  = '{mk(0, 'h13, 1, 2, 0, 0, 2048),  32'h00000013, 2'd1};
    vt[4]  = '{mk(2, 'h63, 0, 1, 2, 0, 5),     32'h00000013, 2'd2};
    vt[5]  = '{mk(3, 'h13, 1, 2, 3, 0, 5000),  32'h00000013, 2'd3};
    vt[6]  = '{mk(0, 'h13, 0, 0, 0, 0, 2047),  32'h7FF00013, 2'd0};
    vt[7]  = '{mk(0, 'h13, 0, 0, 0, 0, -2048), 32'h80000013, 2'd0};
    vt[8]  = '{mk(0, 'h13, 0, 0, 0, 0, -2049), 32'h00000013, 2'd1};
    vt[9]  = '{mk(2, 'h63, 0, 0, 0, 0, 4094),  32'h7E000FE3, 2'd0};
    vt[10] = '{mk(2, 'h63, 0, 0, 0, 0, -4096), 32'h80000063, 2'd0};
    vt[11] = '{mk(2, 'h63, 0, 0, 0, 0, 4096),  32'h00000013, 2'd1};
    vt[12] = '{mk(2, 'h63, 0, 0, 0, 0, 4097),  32'h00000013, 2'd2};
    vt[13] = '{mk(1, 'h23, 0, 0, 0, 0, -2048), 32'h80000023, 2'd0};
    vt[14] = '{mk(1, 'h23, 0, 0, 0, 0, 2048),  32'h00000013, 2'd1};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.err_clr = 1'b0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instr", bus.instr_out, 32'd0);
    chk("rst_err_out", {31'd0, bus.err_out}, 32'd0);
    chk("rst_code", {30'd0, bus.err_code}, 32'd0);
    chk("rst_count", {{(32-CW){1'b0}}, bus.err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      send_lat(vt[i].f, vt[i].instr, vt[i].code);
      if (i == 5) chk("count_after_3err", {{(32-CW){1'b0}}, bus.err_count}, 32'd3);
    end
    // Backpressure: third word must be refused while both stages are full.
    fa = mk(0, 'h13, 3, 4, 0, 1, 100);
    fb = mk(1, 'h23, 0, 6, 7, 2, -20);
    fc = mk(2, 'h63, 0, 8, 9, 1, 64);
    bus.out_ready = 1'b0;
    send(fa);
    send(fb);
    drive(fc);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold", bus.instr_out, model(fa).instr);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(fc);
    drain();
    // Random traffic under random backpressure.
    rand_bp = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      int imm;
      int bnd[9] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096};
      case ($urandom % 4)
        0: imm = int'($urandom_range(10000)) - 5000;
        1: imm = bnd[$urandom % 9];
        2: imm = int'($urandom);
        default: imm = (int'($urandom_range(4000)) - 2000) * 2;
      endcase
      send(mk(int'($urandom % 4), int'($urandom), int'($urandom), int'($urandom),
              int'($urandom), int'($urandom), imm));
      repeat ($urandom % 3) @(posedge clk);
      #1;
    end
    @(posedge clk);
    rand_bp = 1'b0;
    #2;
    drain();
    // Counter saturation and clear-beats-increment.
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    for (int k = 0; k < (1 << CW) + 2; k++) send(mk(3, 'h13, 0, 0, 0, 0, 1));
    drain();
    @(negedge clk);
    chk("count_saturated", {{(32-CW){1'b0}}, bus.err_count}, (1 << CW) - 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(mk(3, 'h13, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", {{(32-CW){1'b0}}, bus.err_count}, 32'd0);
    chk("clr_delivered", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(mk(0, 'h13, 1, 1, 0, 0, 1));
    send(mk(0, 'h13, 2, 2, 0, 0, 2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_instr", bus.instr_out, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q.delete();
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send_lat(vt[0].f, vt[0].instr, vt[0].code);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
